// File: rtl/ram8_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram8_if
//  Purpose  : Request/response bundle between a requester and ram8_ctrl.
//             Request channel : req_valid/req_ready handshake with req_we,
//                               req_addr[2:0], req_wdata[15:0].
//             Response channel: rsp_valid/rsp_ready handshake with
//                               rsp_rdata[15:0].
//             With RAM8_PARITY_EN defined the bundle also carries
//             par_inject (requester -> block) and parity_err (block ->
//             requester).
//  Modports : master (requester side), slave (ram8_ctrl side)
//  Revision : 1.0  initial release
// ============================================================================
interface ram8_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
`ifdef RAM8_PARITY_EN
    logic        par_inject;
    logic        parity_err;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
`ifdef RAM8_PARITY_EN
        output par_inject,
        input  parity_err,
`endif
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
`ifdef RAM8_PARITY_EN
        input  par_inject,
        output parity_err,
`endif
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ram8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram8_ctrl
//  Purpose  : Eight-word x 16-bit register memory behind a valid/ready
//             request channel and a one-deep registered read-response slot.
//             Reads have a latency of one cycle; writes produce no response.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - ram8_if.slave (request/response handshake bundle)
//  Options  : RAM8_PARITY_EN - adds an even-parity bit per word, the
//             par_inject input and the parity_err output.
//  Revision : 1.0  initial release
// ============================================================================
module ram8_ctrl (
    input  wire logic clk,
    input  wire logic rst,
    ram8_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic [15:0] r_mem [0:7];
`ifdef RAM8_PARITY_EN
    logic        r_par [0:7];
    logic        r_parity_err;
`endif

    logic w_req_ready;
    logic w_acc_wr;
    logic w_acc_rd;

    // The slot can take a new request if it is empty or being drained now.
    assign w_req_ready = !r_rsp_valid || bus.rsp_ready;
    assign w_acc_wr    = bus.req_valid && w_req_ready &&  bus.req_we;
    assign w_acc_rd    = bus.req_valid && w_req_ready && !bus.req_we;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
`ifdef RAM8_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= 16'h0000;
`ifdef RAM8_PARITY_EN
                r_par[i] <= 1'b0;
`endif
            end
`ifdef RAM8_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            // A write and a read are never accepted on the same edge, so the
            // read below always sees settled memory contents.
            if (w_acc_wr) begin
                r_mem[bus.req_addr] <= bus.req_wdata;
`ifdef RAM8_PARITY_EN
                r_par[bus.req_addr] <= (^bus.req_wdata) ^ bus.par_inject;
`endif
            end

            if (w_acc_rd) begin
                r_rsp_rdata <= r_mem[bus.req_addr];
`ifdef RAM8_PARITY_EN
                r_parity_err <= (^r_mem[bus.req_addr]) ^ r_par[bus.req_addr];
`endif
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_acc_rd) begin
                        r_state     <= ST_FULL;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // A read accepted while draining keeps the slot full
                    // with the reloaded data.
                    if (bus.rsp_ready && !w_acc_rd) begin
                        r_state     <= ST_EMPTY;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram8_ctrl
//  Purpose  : Self-checking bench for ram8_ctrl: directed scenarios followed
//             by random traffic, all compared against a behavioural model
//             (memory array + one-slot response holder).
//  Options  : RAM8_PARITY_EN - also exercises the parity feature.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram8_ctrl;

    logic clk;
    logic rst;
    ram8_if bus ();

    ram8_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_mem [0:7];
    logic        m_par [0:7];
    logic        m_valid;
    logic [15:0] m_rdata;
    logic        m_perr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = 16'h0000;
            m_par[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_rdata = 16'h0000;
        m_perr  = 1'b0;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] a,
                         input logic [15:0] d, input logic rr, input logic pi);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
`ifdef RAM8_PARITY_EN
        bus.par_inject = pi;
`else
        if (pi) ;
`endif
    endtask

    // One clock cycle with the currently driven inputs; the model applies
    // the handshake rules, then the DUT outputs are compared after the edge.
    task automatic step();
        logic       acc;
        logic [2:0] a;
        logic       pi;
        #1;
        chk("req_ready", bus.req_ready, !m_valid || bus.rsp_ready);
        acc = bus.req_valid && (!m_valid || bus.rsp_ready);
        a   = bus.req_addr;
`ifdef RAM8_PARITY_EN
        pi  = bus.par_inject;
`else
        pi  = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (m_valid && bus.rsp_ready) m_valid = 1'b0;
        if (acc && bus.req_we) begin
            m_mem[a] = bus.req_wdata;
            m_par[a] = (^bus.req_wdata) ^ pi;
        end else if (acc) begin
            m_valid = 1'b1;
            m_rdata = m_mem[a];
            m_perr  = (^m_mem[a]) ^ m_par[a];
        end
        chk("rsp_valid", bus.rsp_valid, m_valid);
        if (m_valid) begin
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
`ifdef RAM8_PARITY_EN
            chk("parity_err", bus.parity_err, m_perr);
`endif
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic pi);
        drive(1'b1, 1'b1, a, d, 1'b1, pi);
        step();
    endtask

    task automatic rd(input logic [2:0] a);
        drive(1'b1, 1'b0, a, 16'h0000, 1'b1, 1'b0);
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        step();
    endtask

    initial begin
        model_reset();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 16'h0000);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Every word reads zero after reset
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            chk("rd_after_rst", bus.rsp_rdata, 16'h0000);
        end
        idle();

        // Write then read the same word; neighbours untouched
        wr(3'd3, 16'hA5A5, 1'b0);
        rd(3'd3);
        chk("rd3_valid", bus.rsp_valid, 1'b1);
        chk("rd3_data", bus.rsp_rdata, 16'hA5A5);
        rd(3'd2);
        chk("rd2_data", bus.rsp_rdata, 16'h0000);
        rd(3'd4);
        chk("rd4_data", bus.rsp_rdata, 16'h0000);
        idle();

        // Back-pressure: response held, requests (even writes) refused
        drive(1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 3'd3, 16'hDEAD, 1'b0, 1'b0);
            step();
            chk("stall_req_ready", bus.req_ready, 1'b0);
            chk("stall_rdata", bus.rsp_rdata, 16'hA5A5);
        end
        idle();
        chk("drain_req_ready", bus.req_ready, 1'b1);
        rd(3'd3);
        chk("no_write_in_stall", bus.rsp_rdata, 16'hA5A5);
        idle();

        // Back-to-back reads
        wr(3'd1, 16'h1111, 1'b0);
        wr(3'd2, 16'h2222, 1'b0);
        wr(3'd3, 16'h3333, 1'b0);
        rd(3'd1);
        chk("b2b_1", bus.rsp_rdata, 16'h1111);
        rd(3'd2);
        chk("b2b_2", bus.rsp_rdata, 16'h2222);
        rd(3'd3);
        chk("b2b_3", bus.rsp_rdata, 16'h3333);
        chk("b2b_valid", bus.rsp_valid, 1'b1);
        idle();

        // Asynchronous reset with a pending response
        wr(3'd5, 16'hBEEF, 1'b0);
        drive(1'b1, 1'b0, 3'd5, 16'h0000, 1'b0, 1'b0);
        step();
        chk("pre_rst_data", bus.rsp_rdata, 16'hBEEF);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("arst_mem5", dut.r_mem[5], 16'h0000);
        chk("arst_req_ready", bus.req_ready, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        rd(3'd5);
        chk("rd5_after_rst", bus.rsp_rdata, 16'h0000);
        idle();

`ifdef RAM8_PARITY_EN
        wr(3'd6, 16'h0001, 1'b1);
        rd(3'd6);
        chk("par_err_inj", bus.parity_err, 1'b1);
        wr(3'd6, 16'h0001, 1'b0);
        rd(3'd6);
        chk("par_err_clean", bus.parity_err, 1'b0);
        idle();
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram8_ctrl.md
RAM8_CTRL -- requirements
Module: ram8_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port req_addr, input, 3 bits: word select 0..7.
REQ-008 The block SHALL have port req_wdata, input, 16 bits: write data.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: read data is present.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the read data.
REQ-011 The block SHALL have port rsp_rdata, output, 16 bits: read data.

Function
REQ-012 The block SHALL hold eight 16-bit registered words, mem[0..7].
REQ-013 The block SHALL accept a request on a rising edge where req_valid=1 and req_ready=1.
REQ-014 req_ready SHALL be combinational and equal to (!rsp_valid || rsp_ready).
REQ-015 On an accepted write, mem[req_addr] SHALL take req_wdata at that edge; no response is generated, and the other seven words are unchanged.
REQ-016 On an accepted read, rsp_rdata SHALL take mem[req_addr] at that edge and rsp_valid SHALL be 1 from the next cycle, giving a latency of 1.
REQ-017 The response FSM SHALL have two states. EMPTY (rsp_valid=0) moves to FULL on an accepted read. FULL moves to EMPTY on rsp_ready=1 with no accepted read. FULL stays FULL when rsp_ready=1 and a read is accepted in the same cycle, with rsp_rdata reloaded back-to-back.
REQ-018 While rsp_valid=1 and rsp_ready=0, rsp_rdata SHALL be held stable and no request SHALL be accepted.
REQ-019 A write accepted in the same cycle that a response drains SHALL update memory with no effect on rsp_rdata.
REQ-020 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-021 Read data SHALL be sampled before the edge's write, so that no same-edge write-to-read forwarding is needed (writes and reads are never accepted together).
REQ-022 req_addr values SHALL decode one-hot to exactly one word; there is no out-of-range condition.

Reset
REQ-023 Asserting rst SHALL immediately clear mem[0..7] to 16'h0000, rsp_valid to 0 and rsp_rdata to 16'h0000, independent of clk.
REQ-024 A pending response SHALL be discarded on reset mid-operation, and req_ready SHALL read 1 once rst is asserted.
REQ-025 No request SHALL be accepted on an edge where rst=1.

Configuration
REQ-026 When the macro RAM8_PARITY_EN is defined, the block SHALL add a 17th even-parity bit per word, an input par_inject (1 bit) and an output parity_err (1 bit, reset 0).
REQ-027 With RAM8_PARITY_EN defined, an accepted write SHALL store (^req_wdata) ^ par_inject as the word's parity bit.
REQ-028 With RAM8_PARITY_EN defined, an accepted read SHALL register parity_err = (^data) ^ storedparity alongside rsp_rdata, valid while rsp_valid=1.
REQ-029 When RAM8_PARITY_EN is not defined, the ports par_inject and parity_err and all parity storage SHALL be absent, with behaviour otherwise identical.

Verification
REQ-030 The bench SHALL apply reset, then read addresses 0..7, and check that each rsp_rdata=16'h0000 one cycle after accept.
REQ-031 The bench SHALL write 16'hA5A5 to address 3 and then read address 3, and check rsp_rdata=16'hA5A5 with rsp_valid one cycle after the read accept; reads of addresses 2 and 4 SHALL return 16'h0000.
REQ-032 The bench SHALL issue a read of address 3 while holding rsp_ready=0 for 4 cycles, and check rsp_valid=1, req_ready=0 and a stable rsp_rdata throughout; on rsp_ready=1 the response SHALL drain and req_ready=1.
REQ-033 The bench SHALL issue back-to-back reads of addresses 1, 2, 3 with rsp_ready=1 and data 16'h1111/16'h2222/16'h3333, and check three consecutive rsp_valid cycles with the data in order.
REQ-034 The bench SHALL assert rst asynchronously while rsp_valid=1 for address 5 holding 16'hBEEF, and check that rsp_valid=0 and mem[5]=0 immediately, with a subsequent read returning 16'h0000.
REQ-035 With RAM8_PARITY_EN defined, the bench SHALL write 16'h0001 to address 6 with par_inject=1 and read it back, and check parity_err=1; a rewrite with par_inject=0 followed by a read SHALL give parity_err=0.
